dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported data memory between the CPU load/store stage (requester 0) and a DMA/debug loader (requester 1).
- Grants at most one access per cycle. Decides round-robin with a bounded burst for the current owner, so neither side starves.
- Drives the memory's write enable, address and write data; returns read data with registered, one-cycle-late valid.
- Sits between the datapath/DMA and data_memory; the memory reads combinationally and writes on the clock edge.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single-ported data memory between the CPU
// load/store stage (requester 0) and the DMA/debug loader (requester 1).
//
// At most one access is granted per cycle. Arbitration is round-robin, and the
// current owner may keep a bounded burst of up to MAX_BURST consecutive grants
// while the other side waits. The memory reads combinationally and writes at
// the granting clock edge. Read data returns one cycle after the grant.
//
// Optional feature: define DMEM_ARB_ADDR_CHECK_EN to range-check granted
// addresses against DEPTH. An out-of-range access suppresses the write, returns
// 0 for a read, and pulses err. Without the macro, err is tied 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/req1           access request, held until granted
//   we0/we1             1 = write, 0 = read (qualified by req)
//   addr0/addr1         word address
//   wdata0/wdata1       write data
//   gnt0/gnt1           combinational grant; the access completes this cycle
//   rdata0/rdata1       registered read data (holds between reads)
//   rvalid0/rvalid1     one-cycle pulse, the cycle after a granted read
//   mem_we/mem_a/mem_wd memory write enable, address, write data
//   mem_rd              memory combinational read data
//   err                 out-of-range pulse, the cycle after the grant
module dmem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 4,
  parameter int DEPTH     = 4000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          err
);

  localparam int CW = $clog2(MAX_BURST + 1);

  if (MAX_BURST < 1 || DEPTH < 1) begin : g_bad_cfg
    $error("dmem_arbiter: MAX_BURST and DEPTH must be at least 1");
  end

  // IDLE doubles as "no grant" when used for the grant decision.
  typedef enum logic [1:0] {IDLE = 2'd0, R0 = 2'd1, R1 = 2'd2} owner_t;

  owner_t        owner;
  owner_t        last;
  owner_t        g;
  logic [CW-1:0] cnt;
  logic          sel_we;
  logic          acc;
  logic          oob;
  logic          rd0;
  logic          rd1;

  // Grant decision: a lone requester always wins. On a tie the owner keeps the
  // memory until its burst budget is spent, then the side not served last wins.
  always_comb begin
    g = IDLE;
    if (req0 && !req1) begin
      g = R0;
    end else if (!req0 && req1) begin
      g = R1;
    end else if (req0 && req1) begin
      if (owner != IDLE && cnt < CW'(MAX_BURST)) g = owner;
      else                                       g = (last == R0) ? R1 : R0;
    end
  end

  // Grants are gated by rst_n so nothing reaches the memory during reset.
  assign gnt0 = rst_n && (g == R0);
  assign gnt1 = rst_n && (g == R1);
  assign acc  = gnt0 | gnt1;

  // With no grant the mux rests on requester 0.
  assign mem_a  = (g == R1) ? addr1  : addr0;
  assign mem_wd = (g == R1) ? wdata1 : wdata0;
  assign sel_we = (g == R1) ? we1    : we0;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign oob = (mem_a >= AW'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  assign mem_we = acc & sel_we & ~oob;
  assign rd0    = gnt0 & ~we0;
  assign rd1    = gnt1 & ~we1;

  // Arbitration state and read-return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= IDLE;
      last    <= R1;
      cnt     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (g == IDLE) begin
        owner <= IDLE;
        cnt   <= '0;
      end else if (g == owner) begin
        if (cnt < CW'(MAX_BURST)) cnt <= cnt + CW'(1);
      end else begin
        owner <= g;
        cnt   <= CW'(1);
      end
      if (g != IDLE) last <= g;

      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) rdata0 <= oob ? '0 : mem_rd;
      if (rd1) rdata1 <= oob ? '0 : mem_rd;
    end
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= acc & oob;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 4096-word memory.
// Background memory contents are mem[i] = 0xC000_0000 + i, and mem[5] = 0xA5A5A5A5.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we, err;
  logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;

  logic [DW-1:0] mem [4096];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(4), .DEPTH(4000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .err(err)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[11:0]];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC000_0000 + i;
    mem[5] = 32'hA5A5_A5A5;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_a[11:0]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with a pending write: grant and write enable must stay gated.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5;
    tick();
    check("rst_gnt0", gnt0, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_err", err, 0);
    tick();
    rst_n = 1'b1;

    // Single read by R0 at address 5.
    we0 = 1'b0;
    #2;
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_mem_a", mem_a, 5);
    check("rd_mem_we", mem_we, 0);
    tick();
    req0 = 1'b0; addr0 = 32'd7; addr1 = 32'd9;
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rdata0", rdata0, 32'hA5A5_A5A5);
    check("rd_rvalid1", rvalid1, 0);
    check("rd_rdata1", rdata1, 0);
    #2;
    check("idle_gnt0", gnt0, 0);
    check("idle_mem_a", mem_a, 7);
    tick();
    check("rd_pulse_end", rvalid0, 0);
    check("rd_hold", rdata0, 32'hA5A5_A5A5);

    // Both requesters reading continuously: bursts of four, R0 first.
    do_reset();
    req0 = 1'b1; addr0 = 32'd1; req1 = 1'b1; addr1 = 32'd2;
    for (int i = 0; i < 12; i++) begin
      logic e1;
      e1 = ((i / 4) % 2) == 1;
      #2;
      check($sformatf("burst_gnt0_%0d", i), gnt0, !e1);
      check($sformatf("burst_gnt1_%0d", i), gnt1, e1);
      tick();
      if (e1) check($sformatf("burst_rdata1_%0d", i), rdata1, 32'hC000_0002);
      else    check($sformatf("burst_rdata0_%0d", i), rdata0, 32'hC000_0001);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // R1 alone for 10 cycles saturates its burst count; R0 then wins at once.
    req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("lone_gnt1_%0d", i), gnt1, 1);
      tick();
    end
    req0 = 1'b1;
    #2;
    check("steal_gnt0", gnt0, 1);
    check("steal_gnt1", gnt1, 0);
    check("steal_mem_a", mem_a, 1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // R1 writes address 20, then R0 reads it back.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd20; wdata1 = 32'h1234_5678;
    #2;
    check("wr_gnt1", gnt1, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_a", mem_a, 20);
    check("wr_mem_wd", mem_wd, 32'h1234_5678);
    tick();
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd20;
    #2;
    check("raw_gnt0", gnt0, 1);
    check("raw_mem_we", mem_we, 0);
    check("wr_no_rvalid1", rvalid1, 0);
    tick();
    req0 = 1'b0;
    check("raw_rvalid0", rvalid0, 1);
    check("raw_rdata0", rdata0, 32'h1234_5678);

    // Reset dropped mid-stream while both are reading.
    req0 = 1'b1; addr0 = 32'd1; req1 = 1'b1; addr1 = 32'd2;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_gnt0", gnt0, 0);
    check("mid_gnt1", gnt1, 0);
    check("mid_mem_we", mem_we, 0);
    check("mid_rvalid0", rvalid0, 0);
    check("mid_rvalid1", rvalid1, 0);
    check("mid_rdata0", rdata0, 0);
    check("mid_rdata1", rdata1, 0);
    tick();
    rst_n = 1'b1;
    #2;
    check("post_rst_gnt0", gnt0, 1);
    check("post_rst_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    check("post_rst_rdata0", rdata0, 32'hC000_0001);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    // Out-of-range write then read: no write, zero data, err pulses.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd4000; wdata0 = 32'hDEAD_BEEF;
    #2;
    check("oob_wr_gnt0", gnt0, 1);
    check("oob_wr_mem_we", mem_we, 0);
    tick();
    we0 = 1'b0;
    check("oob_wr_err", err, 1);
    check("oob_wr_rvalid0", rvalid0, 0);
    #2;
    check("oob_rd_gnt0", gnt0, 1);
    check("oob_rd_mem_we", mem_we, 0);
    tick();
    req0 = 1'b0;
    check("oob_rd_err", err, 1);
    check("oob_rd_rvalid0", rvalid0, 1);
    check("oob_rd_rdata0", rdata0, 0);
    tick();
    check("oob_err_end", err, 0);
`else
    // Without the range check, address 4000 passes straight through.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4000;
    #2;
    check("far_gnt0", gnt0, 1);
    check("far_mem_a", mem_a, 4000);
    tick();
    req0 = 1'b0;
    check("far_rvalid0", rvalid0, 1);
    check("far_rdata0", rdata0, 32'hC000_0FA0);
    check("far_err", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
